ram: RTL
========

# ram

Data RAM and output-port chip on the 4-bit multiplexed processor bus, the peer of the program ROM. It shares the ROM's eight-subcycle bus timing and decodes SRC and I/O instructions qualified by `cmd`. It holds 4 registers × (16 main + 4 status) nibbles and one 4-bit output port. During the X2 subcycle it either accepts write data from the CPU or drives read data back to it.

## Interface
- `CHIP_ID`, default 2'b00: chip select matched against SRC data bits [3:2].
- `clock`  in  1: bus clock, one subcycle per edge.
- `reset`  in  1: reset, synchronous, active-high; clock clock.
- `sync`  in  1: high during X3 (subcycle 7); realigns the subcycle counter.
- `cmd`  in  1: active-low RAM command strobe from CPU.
- `data_i`  in  4: bus data from CPU.
- `data_o`  out  4: bus data driven by this chip; 0 when not driving.
- `data_en`  out  1: bus drive enable.
- `io_out`  out  4: output port register.

## Operation
- Subcycle counter `cycle` 0..7 = A1,A2,A3,M1,M2,X1,X2,X3.
  - Reset sets it to 0.
  - `sync`=1 loads 0 on the next edge; otherwise it increments with wrap 7→0.
- SRC: when `cmd`=0 at cycle 6:
  - If `data_i[3:2]==CHIP_ID`: set `selected`, latch `reg_sel=data_i[1:0]`.
  - Otherwise clear `selected`.
  - At cycle 7 of the same instruction, if `selected`: latch `char_sel=data_i`.
  - Selection persists until the next SRC.
- I/O instruction: when `cmd`=0 at cycle 4 and `selected`: latch `op=data_i` and set `op_active`. `op_active` clears at cycle 7.
- Execute at cycle 6 when `op_active`:
  - Writes, sampled from `data_i` at the end of cycle 6:
    - 0 WRM: write `main[reg_sel][char_sel]`.
    - 1 WMP: write `io_out`.
    - 4..7 WR0..WR3: write `status[reg_sel][op-4]`.
  - Reads, drive `data_o`, `data_en`=1:
    - 8 SBM, 9 RDM, B ADM: drive `main[reg_sel][char_sel]`.
    - C..F RD0..RD3: drive `status[reg_sel][op-C]`.
  - 2, 3, A (ROM-port ops): no action, no drive.
- When `cmd`=0 at cycle 6 for SRC, no execute happens, since `op_active` is 0 in an SRC instruction.
- Storage is not cleared by reset. Its contents are undefined until written. The bench must write before read.

## Timing
- Reset values:
  - `data_o`=0, `data_en`=0, `io_out`=0.
  - `selected`=0, `op_active`=0, `reg_sel`=0, `char_sel`=0, `cycle`=0.
- Read path: `data_en`/`data_o` are combinational from `cycle==6 && op_active && op∈{8,9,B,C..F}`. Data is valid within cycle 6 only.
- Write path: storage and `io_out` update on the clock edge ending cycle 6. `io_out` is visible from cycle 7.
- SRC to first usable I/O instruction: the next instruction cycle; zero dead cycles.
- Reset mid-instruction aborts it. No write occurs on the edge where `reset`=1.
- `sync` asserted at cycle ≠7 realigns immediately; any in-flight `op_active` is cleared.
- Two chips with equal `CHIP_ID` is a system error. No arbitration is provided.

## Structure
- Shared package `bus_pkg`:
  - Subcycle constants `SC_A1..SC_X3`.
  - I/O opcode constants `IO_WRM, IO_WMP, IO_WRR, IO_WPM, IO_WR0..3, IO_SBM, IO_RDM, IO_RDR, IO_ADM, IO_RD0..3`.
- The ROM adopts the same package.
- One sub-module, `ram_array`: 80×4 storage with one synchronous write port and one asynchronous read port. The address is {reg, status_flag, index}.

## Test plan
- Reset, then idle 16 cycles: `io_out`=0 and `data_en`=0 throughout.
- SRC `data`=0x0/0x5, then WRM with X2 data 0xA, then SRC same, then RDM: `data_o`=0xA and `data_en`=1 at cycle 6 only.
- CHIP_ID=1; SRC with 0x0: WMP 0x7 leaves `io_out`=0. SRC with 0x4: WMP 0x7 gives `io_out`=0x7 from cycle 7.
- SRC reg 2: WR3 with 0xC, then RD3 returns 0xC. RD3 after SRC reg 1 returns that register's written value, proving isolation.
- Opcode 0x2 (WRR) while selected: no storage or port change, `data_en` stays 0.
- Assert `reset` at cycle 5 of a WRM with data 0xF: location keeps its prior value and `cycle` restarts at 0. Also assert `sync` at cycle 3: the counter reads 0 next.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared 4-bit bus definitions: subcycle numbering, I/O opcodes and
// the data RAM address map used by the RAM and ROM chips.
package bus_pkg;

    localparam logic [2:0] SC_A1 = 3'd0;
    localparam logic [2:0] SC_A2 = 3'd1;
    localparam logic [2:0] SC_A3 = 3'd2;
    localparam logic [2:0] SC_M1 = 3'd3;
    localparam logic [2:0] SC_M2 = 3'd4;
    localparam logic [2:0] SC_X1 = 3'd5;
    localparam logic [2:0] SC_X2 = 3'd6;
    localparam logic [2:0] SC_X3 = 3'd7;

    localparam logic [3:0] IO_WRM = 4'h0;
    localparam logic [3:0] IO_WMP = 4'h1;
    localparam logic [3:0] IO_WRR = 4'h2;
    localparam logic [3:0] IO_WPM = 4'h3;
    localparam logic [3:0] IO_WR0 = 4'h4;
    localparam logic [3:0] IO_WR1 = 4'h5;
    localparam logic [3:0] IO_WR2 = 4'h6;
    localparam logic [3:0] IO_WR3 = 4'h7;
    localparam logic [3:0] IO_SBM = 4'h8;
    localparam logic [3:0] IO_RDM = 4'h9;
    localparam logic [3:0] IO_RDR = 4'hA;
    localparam logic [3:0] IO_ADM = 4'hB;
    localparam logic [3:0] IO_RD0 = 4'hC;
    localparam logic [3:0] IO_RD1 = 4'hD;
    localparam logic [3:0] IO_RD2 = 4'hE;
    localparam logic [3:0] IO_RD3 = 4'hF;

    localparam int RAM_WORDS = 80;

    function automatic logic is_ram_read(input logic [3:0] op);
        return (op == IO_SBM) || (op == IO_RDM) || (op == IO_ADM) ||
               (op[3:2] == 2'b11);
    endfunction

    function automatic logic is_ram_write(input logic [3:0] op);
        return (op == IO_WRM) || (op[3:2] == 2'b01);
    endfunction

    // {reg, status, index} -> reg*20 + (status ? 16+index[1:0] : index)
    function automatic logic [6:0] ram_index(input logic [6:0] a);
        logic [6:0] base;
        logic [6:0] off;
        base = {1'b0, a[6:5], 4'b0000} + {3'b000, a[6:5], 2'b00};
        off  = a[4] ? {5'b00100, a[1:0]} : {3'b000, a[3:0]};
        return base + off;
    endfunction

endpackage

// File: rtl/ram_array.sv
// 80 x 4-bit storage for the data RAM: one synchronous write port
// and one asynchronous read port sharing a single address.
module ram_array
    import bus_pkg::*;
(
    input  logic       clock,
    input  logic       we_i,
    input  logic [6:0] addr_i,
    input  logic [3:0] wdata_i,
    output logic [3:0] rdata_o
);

    logic [3:0] mem_q [0:RAM_WORDS-1];
    logic [6:0] idx;

    assign idx = ram_index(addr_i);

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[idx] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx];

endmodule

// File: rtl/ram.sv
// Data RAM and output port chip on the multiplexed 4-bit bus; decodes
// SRC and I/O instructions and transfers data during X2.
module ram
    import bus_pkg::*;
#(
    parameter logic [1:0] CHIP_ID = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sync,
    input  logic       cmd,
    input  logic [3:0] data_i,
    output logic [3:0] data_o,
    output logic       data_en,
    output logic [3:0] io_out
);

    logic [2:0] cycle_q, cycle_d;
    logic       selected_q, selected_d;
    logic       src_q, src_d;
    logic [1:0] reg_sel_q, reg_sel_d;
    logic [3:0] char_sel_q, char_sel_d;
    logic [3:0] op_q, op_d;
    logic       op_active_q, op_active_d;
    logic [3:0] io_q, io_d;

    logic       exec;
    logic       we;
    logic [6:0] addr;
    logic [3:0] rdata;

    assign exec = op_active_q && (cycle_q == SC_X2);
    // Aborted instructions must not commit their X2 write.
    assign we   = exec && is_ram_write(op_q) && !sync && !reset;
    assign addr = {reg_sel_q, op_q[2],
                   op_q[2] ? {2'b00, op_q[1:0]} : char_sel_q};

    always_comb begin
        cycle_d     = sync ? SC_A1 : cycle_q + 3'd1;
        selected_d  = selected_q;
        src_d       = 1'b0;
        reg_sel_d   = reg_sel_q;
        char_sel_d  = char_sel_q;
        op_d        = op_q;
        op_active_d = op_active_q;
        io_d        = io_q;

        if (!cmd && cycle_q == SC_X2) begin
            src_d      = 1'b1;
            selected_d = (data_i[3:2] == CHIP_ID);
            if (data_i[3:2] == CHIP_ID) begin
                reg_sel_d = data_i[1:0];
            end
        end
        if (src_q && cycle_q == SC_X3 && selected_q) begin
            char_sel_d = data_i;
        end
        if (!cmd && cycle_q == SC_M2 && selected_q) begin
            op_d        = data_i;
            op_active_d = 1'b1;
        end
        if (exec && op_q == IO_WMP && !sync) begin
            io_d = data_i;
        end
        if (cycle_q == SC_X3 || sync) begin
            op_active_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q     <= SC_A1;
            selected_q  <= 1'b0;
            src_q       <= 1'b0;
            reg_sel_q   <= 2'b00;
            char_sel_q  <= 4'h0;
            op_q        <= 4'h0;
            op_active_q <= 1'b0;
            io_q        <= 4'h0;
        end else begin
            cycle_q     <= cycle_d;
            selected_q  <= selected_d;
            src_q       <= src_d;
            reg_sel_q   <= reg_sel_d;
            char_sel_q  <= char_sel_d;
            op_q        <= op_d;
            op_active_q <= op_active_d;
            io_q        <= io_d;
        end
    end

    ram_array u_array (
        .clock   (clock),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (data_i),
        .rdata_o (rdata)
    );

    assign data_en = exec && is_ram_read(op_q);
    assign data_o  = data_en ? rdata : 4'h0;
    assign io_out  = io_q;

endmodule
